// File: rtl/alu_issue_stage_if.sv
// Bundle of the issue stage's three handshakes: the command input, the
// operand/result link to the combinational ALU, and the result output.
//
// valid/ready rule for both in_* and out_*: a transfer happens on a rising
// clk edge where valid and ready are both 1. The sender keeps valid and its
// payload stable until that edge, and ready never depends on valid.
interface alu_issue_stage_if #(
   parameter int WIDTH = 8
);
   // Command input
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_chain;
   logic [3:0]       in_opcode;
   // ALU link
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic             alu_cin;
   logic [3:0]       alu_opcode;
   logic [WIDTH-1:0] alu_result;
   logic             alu_cout;
   // Result output
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_cout;
   logic             out_zero;
   logic             out_err;

   // The issue stage itself
   modport master (
      input  in_valid, in_a, in_b, in_cin, in_chain, in_opcode,
      output in_ready,
      output alu_a, alu_b, alu_cin, alu_opcode,
      input  alu_result, alu_cout,
      output out_valid, out_result, out_cout, out_zero, out_err,
      input  out_ready
   );

   // Its environment: command producer, ALU and result consumer
   modport slave (
      output in_valid, in_a, in_b, in_cin, in_chain, in_opcode,
      input  in_ready,
      input  alu_a, alu_b, alu_cin, alu_opcode,
      output alu_result, alu_cout,
      input  out_valid, out_result, out_cout, out_zero, out_err,
      output out_ready
   );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue/capture stage in front of a single-cycle combinational ALU.
// Commands are queued in a small FIFO, issued to registered ALU operands,
// and the ALU outputs are captured one cycle later, sanitised and offered
// on a valid/ready output. An internal carry register links ADD chains.
module alu_issue_stage #(
   parameter int WIDTH      = 8,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_issue_stage_if.master    bus,
   output logic [1:0]           o_dbg_state
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [3:0] OP_ADD  = 4'b0101;
   localparam logic [3:0] OP_DIV  = 4'b1000;
   localparam logic [3:0] OP_LAST = 4'b1010;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
      logic             chain;
      logic [3:0]       opcode;
   } cmd_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   cmd_t             r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   state_t           r_state;
   state_t           w_next;
   logic             r_carry;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_capture;
   logic             w_release;
   logic             w_err;
   logic             w_is_add;
   cmd_t             w_head;

   // in_ready looks only at the registered full flag, so a pop in the same
   // cycle never opens a slot early and there is no path from out_ready.
   assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_empty      = (r_count == '0);
   assign bus.in_ready = !rst && !w_full;
   assign w_push       = bus.in_valid && bus.in_ready;
   assign w_head       = r_mem[r_rd_ptr];
   assign o_dbg_state  = r_state;

   // Capture-time checks work on the registered ALU operands.
   assign w_is_add = (bus.alu_opcode == OP_ADD);
   assign w_err    = (bus.alu_opcode > OP_LAST) ||
                     ((bus.alu_opcode == OP_DIV) && (bus.alu_b == '0));

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // FSM next state and the pop/capture/release strobes
   always_comb begin
      w_next    = r_state;
      w_pop     = 1'b0;
      w_capture = 1'b0;
      w_release = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop  = 1'b1;
               w_next = S_EXEC;
            end
         end
         S_EXEC: begin
            w_capture = 1'b1;
            w_next    = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) begin
               w_release = 1'b1;
               if (!w_empty) begin
                  w_pop  = 1'b1;
                  w_next = S_EXEC;
               end else begin
                  w_next = S_IDLE;
               end
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Command FIFO storage (no reset needed: occupancy is tracked by r_count)
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= '{a: bus.in_a, b: bus.in_b, cin: bus.in_cin,
                              chain: bus.in_chain, opcode: bus.in_opcode};
      end
   end

   // FIFO pointers and occupancy; a push and pop together cancel out
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // ALU operand registers load only on pop; chained commands take the carry
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.alu_a      <= '0;
         bus.alu_b      <= '0;
         bus.alu_cin    <= 1'b0;
         bus.alu_opcode <= '0;
      end else if (w_pop) begin
         bus.alu_a      <= w_head.a;
         bus.alu_b      <= w_head.b;
         bus.alu_cin    <= w_head.chain ? r_carry : w_head.cin;
         bus.alu_opcode <= w_head.opcode;
      end
   end

   // Result capture and sanitising; only an error-free ADD moves the carry
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid  <= 1'b0;
         bus.out_result <= '0;
         bus.out_cout   <= 1'b0;
         bus.out_zero   <= 1'b0;
         bus.out_err    <= 1'b0;
         r_carry        <= 1'b0;
      end else if (w_capture) begin
         bus.out_valid <= 1'b1;
         if (w_err) begin
            bus.out_result <= '0;
            bus.out_cout   <= 1'b0;
            bus.out_zero   <= 1'b1;
            bus.out_err    <= 1'b1;
         end else begin
            bus.out_result <= bus.alu_result;
            bus.out_zero   <= (bus.alu_result == '0);
            bus.out_err    <= 1'b0;
            bus.out_cout   <= w_is_add ? bus.alu_cout : 1'b0;
            if (w_is_add) r_carry <= bus.alu_cout;
         end
      end else if (w_release) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule
